// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared types and constants for the dino game score path.
//   state_e   : game FSM state (StIdle / StRun / StOver)
//   BcdW      : width of one BCD digit
//   all_nines : packed BCD constant with the lowest n digits set to 9
// -----------------------------------------------------------------------------
package dino_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StOver
   } state_e;

   localparam int unsigned BcdW      = 4;
   localparam int unsigned MaxDigits = 8;

   // Returns a 32-bit packed BCD value with digits [n-1:0] equal to 9.
   function automatic logic [31:0] all_nines(input int unsigned n);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < MaxDigits; i++) begin
         if (i < n) begin
            r[BcdW*i +: BcdW] = 4'd9;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One decimal digit of a ripple BCD counter.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   inc_i   : add one to the digit this cycle
//   clr_i   : clear the digit to 0 (wins over inc_i)
//   digit_o : current digit value (0..9)
//   carry_o : inc_i applied while the digit holds 9 (feeds the next digit)
// -----------------------------------------------------------------------------
module bcd_digit
   import dino_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            inc_i,
   input  logic            clr_i,
   output logic [BcdW-1:0] digit_o,
   output logic            carry_o
);

   logic [BcdW-1:0] digit_q;
   logic [BcdW-1:0] digit_d;
   logic            at_nine;

   assign at_nine = (digit_q == 4'd9);

   always_comb begin
      digit_d = digit_q;
      if (clr_i) begin
         digit_d = '0;
      end else if (inc_i) begin
         digit_d = at_nine ? '0 : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

   assign digit_o = digit_q;
   assign carry_o = inc_i & at_nine;

endmodule

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
// BCD score, speed level and session high-score tracker for the dino game.
// Qualified game ticks are divided by TICK_DIV into score increments; every
// carry into digit MILESTONE_DIGIT raises the level and pulses o_milestone.
//
// Parameters:
//   NUM_DIGITS      : BCD digits in score / high score (1..8)
//   TICK_DIV        : qualified ticks per score point (>=1)
//   MILESTONE_DIGIT : digit whose incoming carry marks a milestone
//   LEVEL_W         : width of o_level
//
// Ports:
//   clk           : clock
//   rst           : synchronous active-high reset
//   i_game_start  : start pulse, enters RUN from any state and clears the run
//   i_game_over   : game-over pulse, honoured only in RUN
//   i_game_frozen : pause, masks ticks
//   i_game_tick   : game tick
//   o_score       : packed BCD score, digit 0 in bits [3:0]
//   o_hiscore     : packed BCD session high score
//   o_level       : speed level, saturating
//   o_new_record  : last finished run beat the high score
//   o_milestone   : one-cycle pulse per milestone
//
// Build option: define SCORE_HISCORE_EN to build the high-score register,
// comparator and o_new_record; otherwise both outputs are tied to 0.
// -----------------------------------------------------------------------------
module score_keeper
   import dino_pkg::*;
#(
   parameter int unsigned NUM_DIGITS      = 4,
   parameter int unsigned TICK_DIV        = 6,
   parameter int unsigned MILESTONE_DIGIT = 2,
   parameter int unsigned LEVEL_W         = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_game_start,
   input  logic                       i_game_over,
   input  logic                       i_game_frozen,
   input  logic                       i_game_tick,
   output logic [BcdW*NUM_DIGITS-1:0] o_score,
   output logic [BcdW*NUM_DIGITS-1:0] o_hiscore,
   output logic [LEVEL_W-1:0]         o_level,
   output logic                       o_new_record,
   output logic                       o_milestone
);

   localparam int unsigned        ScoreW    = BcdW * NUM_DIGITS;
   localparam int unsigned        DivW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DivW-1:0]    DivLast   = DivW'(TICK_DIV - 1);
   localparam logic [31:0]        AllNines  = all_nines(NUM_DIGITS);
   localparam logic [ScoreW-1:0]  ScoreMax  = AllNines[ScoreW-1:0];
   localparam logic [LEVEL_W-1:0] LevelMax  = {LEVEL_W{1'b1}};

   state_e             state_q;
   logic [DivW-1:0]    div_q;
   logic [LEVEL_W-1:0] level_q;
   logic               milestone_q;

   logic [ScoreW-1:0]     score;
   logic [NUM_DIGITS-1:0] dig_inc;
   logic [NUM_DIGITS-1:0] dig_carry;

   logic in_run;
   logic tick_ok;
   logic div_wrap;
   logic score_inc;
   logic milestone_hit;
   logic unused_top_carry;

   assign in_run   = (state_q == StRun);
   // Start and over both win over a tick in the same cycle.
   assign tick_ok  = in_run & i_game_tick & ~i_game_frozen & ~i_game_over & ~i_game_start;
   assign div_wrap = (div_q == DivLast);
   // A full score drops the increment, so no carry (and no milestone) can form.
   assign score_inc = tick_ok & div_wrap & (score != ScoreMax);

   // ---------------------------------------------------------------------------
   // BCD ripple chain
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      if (g == 0) begin : g_first
         assign dig_inc[g] = score_inc;
      end else begin : g_rest
         assign dig_inc[g] = dig_carry[g-1];
      end

      bcd_digit u_digit (
         .clk_i   (clk),
         .rst_i   (rst),
         .inc_i   (dig_inc[g]),
         .clr_i   (i_game_start),
         .digit_o (score[BcdW*g +: BcdW]),
         .carry_o (dig_carry[g])
      );
   end

   // Saturation gating keeps the top digit from ever carrying out.
   assign unused_top_carry = dig_carry[NUM_DIGITS-1];
   assign milestone_hit    = dig_carry[MILESTONE_DIGIT-1];

   // ---------------------------------------------------------------------------
   // FSM, divider, milestone and level
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         div_q       <= '0;
         level_q     <= '0;
         milestone_q <= 1'b0;
      end else begin
         milestone_q <= 1'b0;
         if (i_game_start) begin
            state_q <= StRun;
            div_q   <= '0;
            level_q <= '0;
         end else begin
            case (state_q)
               StRun: begin
                  if (i_game_over) begin
                     state_q <= StOver;
                  end else if (tick_ok) begin
                     div_q <= div_wrap ? '0 : div_q + 1'b1;
                     if (milestone_hit) begin
                        milestone_q <= 1'b1;
                        if (level_q != LevelMax) begin
                           level_q <= level_q + 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  // IDLE and OVER only leave on a start pulse.
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // High score
   // ---------------------------------------------------------------------------
`ifdef SCORE_HISCORE_EN
   logic [ScoreW-1:0] hiscore_q;
   logic              new_record_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hiscore_q    <= '0;
         new_record_q <= 1'b0;
      end else if (i_game_start) begin
         new_record_q <= 1'b0;
      end else if (in_run && i_game_over && (score > hiscore_q)) begin
         // Packed BCD orders the same as its decimal value.
         hiscore_q    <= score;
         new_record_q <= 1'b1;
      end
   end

   assign o_hiscore    = hiscore_q;
   assign o_new_record = new_record_q;
`else
   assign o_hiscore    = '0;
   assign o_new_record = 1'b0;
`endif

   assign o_score     = score;
   assign o_level     = level_q;
   assign o_milestone = milestone_q;

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
// Drives two score_keeper instances (4 digits / divide-by-6 and 2 digits /
// divide-by-1) with the same stimulus, checks them every cycle against a
// behavioural model through an expectation queue, and checks table rows and
// hand-written corner sequences against fixed values.
// -----------------------------------------------------------------------------
module tb_score_keeper;

`ifdef SCORE_HISCORE_EN
   localparam bit HiEn = 1'b1;
`else
   localparam bit HiEn = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst    = 1'b0;
   logic start  = 1'b0;
   logic over   = 1'b0;
   logic frozen = 1'b0;
   logic tick   = 1'b0;

   logic [15:0] score1, hi1;
   logic [2:0]  lvl1;
   logic        rec1, ms1;
   logic [7:0]  score2, hi2;
   logic [2:0]  lvl2;
   logic        rec2, ms2;

   score_keeper #(
      .NUM_DIGITS      (4),
      .TICK_DIV        (6),
      .MILESTONE_DIGIT (2),
      .LEVEL_W         (3)
   ) u_dut4 (
      .clk           (clk),
      .rst           (rst),
      .i_game_start  (start),
      .i_game_over   (over),
      .i_game_frozen (frozen),
      .i_game_tick   (tick),
      .o_score       (score1),
      .o_hiscore     (hi1),
      .o_level       (lvl1),
      .o_new_record  (rec1),
      .o_milestone   (ms1)
   );

   score_keeper #(
      .NUM_DIGITS      (2),
      .TICK_DIV        (1),
      .MILESTONE_DIGIT (1),
      .LEVEL_W         (3)
   ) u_dut2 (
      .clk           (clk),
      .rst           (rst),
      .i_game_start  (start),
      .i_game_over   (over),
      .i_game_frozen (frozen),
      .i_game_tick   (tick),
      .o_score       (score2),
      .o_hiscore     (hi2),
      .o_level       (lvl2),
      .o_new_record  (rec2),
      .o_milestone   (ms2)
   );

   // st: 0 idle, 1 run, 2 over; scores held as plain integers
   typedef struct {
      int st;
      int dv;
      int sc;
      int lv;
      int hi;
      bit rec;
      bit ms;
   } mdl_t;

   typedef struct {
      bit          r;
      bit          s;
      bit          o;
      bit          f;
      bit          t;
      int          reps;
      logic [15:0] sc1;
      logic [2:0]  lv1;
      logic [15:0] hi1;
      bit          rec1;
      logic [7:0]  sc2;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   mdl_t m1, m2;
   mdl_t q1[$];
   mdl_t q2[$];
   vec_t vecs[13];

   function automatic mdl_t mstep(mdl_t m, bit r, bit s, bit o, bit f, bit t,
                                  int nd, int td, int md);
      mdl_t n;
      int   maxv;
      int   mv;
      n    = m;
      n.ms = 1'b0;
      maxv = (10 ** nd) - 1;
      mv   = 10 ** md;
      if (r) begin
         n.st = 0; n.dv = 0; n.sc = 0; n.lv = 0; n.hi = 0; n.rec = 1'b0;
      end else if (s) begin
         n.st = 1; n.dv = 0; n.sc = 0; n.lv = 0; n.rec = 1'b0;
      end else if (m.st == 1 && o) begin
         n.st = 2;
         if (HiEn && m.sc > m.hi) begin
            n.hi  = m.sc;
            n.rec = 1'b1;
         end
      end else if (m.st == 1 && t && !f) begin
         if (m.dv == td - 1) begin
            n.dv = 0;
            if (m.sc < maxv) begin
               n.sc = m.sc + 1;
               if (n.sc % mv == 0) begin
                  n.ms = 1'b1;
                  if (n.lv < 7) n.lv = n.lv + 1;
               end
            end
         end else begin
            n.dv = m.dv + 1;
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] to_bcd(int v);
      logic [31:0] r;
      int          x;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock cycle: predict, push, drive, then pop and compare after the edge.
   task automatic step(bit r, bit s, bit o, bit f, bit t);
      mdl_t        e;
      logic [31:0] b;
      logic [31:0] h;
      rst = r; start = s; over = o; frozen = f; tick = t;
      m1 = mstep(m1, r, s, o, f, t, 4, 6, 2);
      q1.push_back(m1);
      m2 = mstep(m2, r, s, o, f, t, 2, 1, 1);
      q2.push_back(m2);
      @(posedge clk);
      #1;
      e = q1.pop_front();
      b = to_bcd(e.sc);
      h = to_bcd(e.hi);
      chk("dut4 cycle {score,hi,level,rec,ms}", 64'({score1, hi1, lvl1, rec1, ms1}),
          64'({b[15:0], h[15:0], e.lv[2:0], e.rec, e.ms}));
      e = q2.pop_front();
      b = to_bcd(e.sc);
      h = to_bcd(e.hi);
      chk("dut2 cycle {score,hi,level,rec,ms}", 64'({score2, hi2, lvl2, rec2, ms2}),
          64'({b[7:0], h[7:0], e.lv[2:0], e.rec, e.ms}));
   endtask

   initial begin
      logic [15:0] h42;
      m1  = '{default: 0};
      m2  = '{default: 0};
      h42 = HiEn ? 16'h0042 : 16'h0000;

      //            r  s  o  f  t  reps  sc1      lv   hi1       rec   sc2
      vecs[0]  = '{1, 0, 0, 0, 0,   2, 16'h0000, 3'd0, 16'h0000, 1'b0, 8'h00};
      vecs[1]  = '{0, 0, 0, 0, 1,  10, 16'h0000, 3'd0, 16'h0000, 1'b0, 8'h00};
      vecs[2]  = '{0, 1, 0, 0, 0,   1, 16'h0000, 3'd0, 16'h0000, 1'b0, 8'h00};
      vecs[3]  = '{0, 0, 0, 0, 1,  60, 16'h0010, 3'd0, 16'h0000, 1'b0, 8'h60};
      vecs[4]  = '{0, 0, 0, 1, 1,  20, 16'h0010, 3'd0, 16'h0000, 1'b0, 8'h60};
      vecs[5]  = '{0, 0, 0, 0, 1, 192, 16'h0042, 3'd0, 16'h0000, 1'b0, 8'h99};
      vecs[6]  = '{0, 0, 1, 0, 0,   1, 16'h0042, 3'd0, h42,      HiEn, 8'h99};
      vecs[7]  = '{0, 0, 0, 0, 1,  30, 16'h0042, 3'd0, h42,      HiEn, 8'h99};
      vecs[8]  = '{0, 1, 0, 0, 0,   1, 16'h0000, 3'd0, h42,      1'b0, 8'h00};
      vecs[9]  = '{0, 0, 0, 0, 1, 252, 16'h0042, 3'd0, h42,      1'b0, 8'h99};
      vecs[10] = '{0, 0, 1, 0, 0,   1, 16'h0042, 3'd0, h42,      1'b0, 8'h99};
      vecs[11] = '{0, 1, 0, 0, 0,   1, 16'h0000, 3'd0, h42,      1'b0, 8'h00};
      vecs[12] = '{0, 0, 0, 0, 1, 594, 16'h0099, 3'd0, h42,      1'b0, 8'h99};

      for (int i = 0; i < 13; i++) begin
         for (int k = 0; k < vecs[i].reps; k++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].o, vecs[i].f, vecs[i].t);
         end
         chk($sformatf("vec%0d score4", i), 64'(score1), 64'(vecs[i].sc1));
         chk($sformatf("vec%0d level4", i), 64'(lvl1), 64'(vecs[i].lv1));
         chk($sformatf("vec%0d hiscore4", i), 64'(hi1), 64'(vecs[i].hi1));
         chk($sformatf("vec%0d record4", i), 64'(rec1), 64'(vecs[i].rec1));
         chk($sformatf("vec%0d score2", i), 64'(score2), 64'(vecs[i].sc2));
      end

      // 0x0099 -> 0x0100: exactly one milestone pulse and level 1.
      for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1);
      chk("pre-rollover score", 64'(score1), 64'h0099);
      chk("pre-rollover no pulse", 64'(ms1), 64'h0);
      step(0, 0, 0, 0, 1);
      chk("rollover score", 64'(score1), 64'h0100);
      chk("rollover pulse", 64'(ms1), 64'h1);
      chk("rollover level", 64'(lvl1), 64'h1);
      step(0, 0, 0, 0, 0);
      chk("pulse one cycle", 64'(ms1), 64'h0);
      chk("level held", 64'(lvl1), 64'h1);
      chk("saturated 2-digit score", 64'(score2), 64'h99);
      chk("saturated 2-digit level", 64'(lvl2), 64'h7);

      // Start and over together: start wins, run proceeds from 0.
      step(0, 1, 1, 0, 0);
      chk("start+over score", 64'(score1), 64'h0);
      chk("start+over level", 64'(lvl1), 64'h0);
      for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1);
      chk("start+over then run", 64'(score1), 64'h0001);

      // Over with a tick that would complete a point: the tick is dropped.
      for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      chk("over beats tick score", 64'(score1), 64'h0001);
      chk("over beats tick hiscore", 64'(hi1), 64'(h42));
      chk("over beats tick record", 64'(rec1), 64'h0);

      // Reset mid-run clears everything including the high score.
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1);
      chk("pre-reset score", 64'(score1), 64'h0001);
      step(1, 0, 0, 0, 1);
      chk("reset outputs dut4", 64'({score1, hi1, lvl1, rec1, ms1}), 64'h0);
      chk("reset outputs dut2", 64'({score2, hi2, lvl2, rec2, ms2}), 64'h0);
      for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 1);
      chk("idle after reset", 64'(score1), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/score_keeper.md
# score_keeper

Parametrised BCD score, level and high-score tracker for the dino game. It replaces the fixed 4-digit score counter between the player controller and the score renderers. It counts game ticks into an N-digit BCD score and raises a speed level every milestone. It also keeps a session high score with a new-record flag, and emits a one-cycle milestone pulse for the audio block.

## Interface
Parameters:
- NUM_DIGITS, 4: BCD digits in score and high score (1..8).
- TICK_DIV, 6: qualified game ticks per score increment (≥1).
- MILESTONE_DIGIT, 2: a milestone occurs when digit index MILESTONE_DIGIT is incremented by carry, i.e. every 10^MILESTONE_DIGIT points (1..NUM_DIGITS-1).
- LEVEL_W, 3: width of level output.

Ports:
- clk, input, 1: system clock; the block has one clock.
- rst, input, 1: reset; synchronous and active-high.
- i_game_start, input, 1: one-cycle start pulse.
- i_game_over, input, 1: one-cycle game-over pulse.
- i_game_frozen, input, 1: pause qualifier; high means ticks are ignored.
- i_game_tick, input, 1: one-cycle 60 Hz tick.
- o_score, output, 4*NUM_DIGITS: packed BCD; digit 0 is bits [3:0].
- o_hiscore, output, 4*NUM_DIGITS: packed BCD high score.
- o_level, output, LEVEL_W: speed level.
- o_new_record, output, 1: high while the last finished run set a new high score.
- o_milestone, output, 1: one-cycle pulse on each milestone.

## Operation
- FSM states:
  - IDLE: entered from reset.
  - RUN.
  - OVER.
- FSM transitions:
  - i_game_start in any state → RUN. On this transition, clear o_score, the divider, o_level and o_new_record.
  - RUN with i_game_over → OVER.
  - OVER waits for the next start.
- Divider:
  - In RUN, with i_game_tick=1 and i_game_frozen=0, the divider increments.
  - When the divider equals TICK_DIV-1, it wraps to 0 and the score increments by 1.
- Score increment is BCD ripple: a digit at 9 wraps to 0 and carries into the next digit.
- Saturation: when the score is all 9s, further increments are dropped. The score holds and no milestone fires.
- Milestone:
  - Fires when a carry enters digit MILESTONE_DIGIT during an increment.
  - o_milestone pulses for one cycle.
  - o_level increments and saturates at 2^LEVEL_W-1.
- Game over (RUN→OVER):
  - If o_score > o_hiscore, then o_hiscore ← o_score and o_new_record ← 1.
  - The comparison is an unsigned compare of the packed vectors, which is valid for BCD.
  - An equal score does not set the record.
- Precedence in the same cycle:
  - start beats over.
  - over beats tick: the tick is discarded and the pre-tick score is compared.
  - frozen masks tick.
- i_game_over outside RUN is ignored. i_game_tick outside RUN is ignored.
- o_hiscore survives game starts and is cleared only by rst.

## Timing
- Reset values: all outputs are 0 (o_score, o_hiscore, o_level, o_new_record, o_milestone); the state is IDLE.
- All outputs are registered.
- o_score updates on the clock edge following the qualifying tick cycle, i.e. 1-cycle latency.
- o_milestone and o_level update on the same edge as the score.
- o_hiscore and o_new_record update 1 cycle after the i_game_over cycle.
- After an i_game_start cycle, o_score reads 0 on the next cycle.
- rst asserted mid-run returns every register to its reset value on the next edge, including o_hiscore.

## Configuration
- SCORE_HISCORE_EN defined: high-score register, comparator and o_new_record are built as described above.
- SCORE_HISCORE_EN undefined: o_hiscore is tied to 0, o_new_record is tied to 0, and no comparator or register is built. All other behaviour is unchanged.

## Structure
- Shared package dino_pkg holds:
  - the state typedef (IDLE/RUN/OVER);
  - a BCD digit width constant (4);
  - the all-nines constant helper.
- One sub-module, bcd_digit:
  - a 4-bit counter with inc/clr inputs and a carry_out (asserted when inc is applied at 9);
  - instantiated NUM_DIGITS times in a generate chain.
- The top holds the FSM, divider, milestone and level logic, and the high-score logic.

## Test plan
- Reset, then start, then 60 unfrozen ticks with TICK_DIV=6 → o_score=0x0010, o_level=0, no milestone.
- Score preset to 0x0099 via ticks, then 6 more ticks → o_score=0x0100, one o_milestone pulse, o_level=1.
- Ticks with i_game_frozen=1, and ticks while in IDLE/OVER → o_score unchanged and the divider unchanged.
- Run to 0x0042, then over → o_hiscore=0x0042 and o_new_record=1. Start again: o_new_record=0. Run to 0x0042, then over → o_hiscore stays 0x0042 and o_new_record=0.
- NUM_DIGITS=2 run to 0x99, then 12 more ticks → o_score holds 0x99 and no milestone beyond those already counted. Then start and over in the same cycle → RUN with o_score=0.
- Without SCORE_HISCORE_EN, run to 0x0005, then over → o_hiscore=0 and o_new_record=0. Then assert rst mid-run → all outputs are 0 on the next cycle.
